// File: rtl/frog_pkg.sv
// Shared types and helpers for the frog-board row.
//   lane_mode_e : road lanes kill on overlap, river lanes must carry the frog
//   DIR_LOW     : lane / carry direction toward index 0
//   DIR_HIGH    : lane / carry direction toward index WIDTH-1
//   rot_low / rot_high : one-cell rotations of a w-bit value held in a vec_t
package frog_pkg;

  typedef enum logic {
    LANE_ROAD  = 1'b0,
    LANE_RIVER = 1'b1
  } lane_mode_e;

  localparam logic DIR_LOW  = 1'b0;
  localparam logic DIR_HIGH = 1'b1;

  // Widest row the helpers support; callers zero-extend into vec_t.
  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] vec_t;

  function automatic vec_t width_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (vec_t'(1) << w) - vec_t'(1);
  endfunction

  // Rotate toward index 0: bit 0 re-enters at bit w-1.
  function automatic vec_t rot_low(input vec_t v, input int unsigned w);
    return (v >> 1) | (vec_t'(v[0]) << (w - 1));
  endfunction

  // Rotate toward index w-1: bit w-1 re-enters at bit 0.
  function automatic vec_t rot_high(input vec_t v, input int unsigned w);
    return ((v << 1) & width_mask(w)) | ((v >> (w - 1)) & vec_t'(1));
  endfunction

endpackage

// File: rtl/frog_lane_row_lane_shifter.sv
// Moving lane for one frog row: pattern register plus period counter.
//   clk, reset  : clock, asynchronous active-low reset
//   load_i      : load pat_i into the lane and restart the period counter
//   pat_i       : lane pattern
//   dir_i       : DIR_LOW rotates toward index 0, DIR_HIGH toward WIDTH-1
//   period_i    : cycles per lane step, 0 freezes the lane
//   lane_o      : registered lane occupancy
//   lane_nxt_o  : lane value that will be registered at the next edge
//   step_o      : high in the cycle the lane advances
module lane_shifter
  import frog_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pat_i,
  input  logic             dir_i,
  input  logic [PER_W-1:0] period_i,
  output logic [WIDTH-1:0] lane_o,
  output logic [WIDTH-1:0] lane_nxt_o,
  output logic             step_o
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lane_q, lane_d;
  logic             step;

  always_comb begin
    cnt_d  = cnt_q;
    lane_d = lane_q;
    step   = 1'b0;
    if (load_i) begin
      lane_d = pat_i;
      cnt_d  = '0;
    end else if (period_i != '0) begin
      // A period shortened below the running count restarts without a step.
      if (cnt_q >= period_i) begin
        cnt_d = '0;
      end else if (cnt_q == period_i - PER_W'(1)) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end
    if (step) begin
      if (dir_i == DIR_HIGH) lane_d = WIDTH'(rot_high(vec_t'(lane_q), WIDTH));
      else                   lane_d = WIDTH'(rot_low(vec_t'(lane_q), WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      lane_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
    end
  end

  assign lane_o     = lane_q;
  assign lane_nxt_o = lane_d;
  assign step_o     = step;

endmodule

// File: rtl/frog_lane_row.sv
// One row of the frog board: frog register, moving lane and local collision.
//   clk, reset          : clock, asynchronous active-low reset
//   L, R, U, D          : one-cycle move pulses (exactly one must be high to move)
//   above_frog          : frog register of the row above (taken on D)
//   below_frog          : frog register of the row below (taken on U)
//   hit                 : global kill, clears the frog, suppresses collision
//   spawn               : place the frog at START_COL
//   lane_load, lane_pat : load a new lane pattern
//   lane_dir, period    : lane rotation direction and cycles per step
//   frog, lane          : registered occupancies
//   row                 : frog | lane for the LED driver
//   hit_o               : registered one-cycle local-collision pulse
module frog_lane_row
  import frog_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          WRAP      = 1'b1,
  parameter lane_mode_e  MODE      = LANE_ROAD,
  parameter int unsigned START_COL = 7,
  parameter int unsigned PER_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L,
  input  logic             R,
  input  logic             U,
  input  logic             D,
  input  logic [WIDTH-1:0] above_frog,
  input  logic [WIDTH-1:0] below_frog,
  input  logic             hit,
  input  logic             spawn,
  input  logic             lane_load,
  input  logic [WIDTH-1:0] lane_pat,
  input  logic             lane_dir,
  input  logic [PER_W-1:0] period,
  output logic [WIDTH-1:0] frog,
  output logic [WIDTH-1:0] lane,
  output logic [WIDTH-1:0] row,
  output logic             hit_o
);

  logic [WIDTH-1:0] frog_q, frog_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] lane_n;
  logic             lane_step;
  logic [WIDTH-1:0] frog_mv, frog_n;
  logic [2:0]       n_moves;
  logic             carry_off, coll;

  lane_shifter #(
    .WIDTH (WIDTH),
    .PER_W (PER_W)
  ) u_lane (
    .clk        (clk),
    .reset      (reset),
    .load_i     (lane_load),
    .pat_i      (lane_pat),
    .dir_i      (lane_dir),
    .period_i   (period),
    .lane_o     (lane),
    .lane_nxt_o (lane_n),
    .step_o     (lane_step)
  );

  always_comb begin
    n_moves = 3'(L) + 3'(R) + 3'(U) + 3'(D);

    frog_mv = frog_q;
    if (hit) begin
      frog_mv = '0;
    end else if (spawn) begin
      frog_mv = WIDTH'(1) << START_COL;
    end else if (n_moves == 3'd1) begin
      // Vertical moves copy the neighbour, which is 0 while the frog is here.
      if (U) begin
        frog_mv = below_frog;
      end else if (D) begin
        frog_mv = above_frog;
      end else if (L) begin
        if (!frog_q[0])  frog_mv = frog_q >> 1;
        else if (WRAP)   frog_mv = WIDTH'(rot_low(vec_t'(frog_q), WIDTH));
      end else begin
        if (!frog_q[WIDTH-1]) frog_mv = frog_q << 1;
        else if (WRAP)        frog_mv = WIDTH'(rot_high(vec_t'(frog_q), WIDTH));
      end
    end

    // A river lane carries the frog along with it, after any move.
    frog_n    = frog_mv;
    carry_off = 1'b0;
    if ((MODE == LANE_RIVER) && lane_step && !hit && !spawn && (frog_mv != '0)) begin
      if (lane_dir == DIR_HIGH) begin
        if (!frog_mv[WIDTH-1]) frog_n = frog_mv << 1;
        else if (WRAP)         frog_n = WIDTH'(rot_high(vec_t'(frog_mv), WIDTH));
        else begin
          frog_n    = '0;
          carry_off = 1'b1;
        end
      end else begin
        if (!frog_mv[0]) frog_n = frog_mv >> 1;
        else if (WRAP)   frog_n = WIDTH'(rot_low(vec_t'(frog_mv), WIDTH));
        else begin
          frog_n    = '0;
          carry_off = 1'b1;
        end
      end
    end

    if (hit)                      coll = 1'b0;
    else if (MODE == LANE_RIVER)  coll = ((frog_n != '0) && ((frog_n & lane_n) == '0)) || carry_off;
    else                          coll = (frog_n & lane_n) != '0;

    frog_d = coll ? '0 : frog_n;
    hit_d  = coll;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frog_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      frog_q <= frog_d;
      hit_q  <= hit_d;
    end
  end

  assign frog  = frog_q;
  assign hit_o = hit_q;
  assign row   = frog_q | lane;

endmodule

// File: tb/tb_frog_lane_row.sv
// Bench for frog_lane_row: three instances (WRAP road, clamp road, clamp river)
// driven cycle by cycle, a behavioural model pushing expectations into a
// scoreboard, plus directed checks of the key scenarios.
module tb_frog_lane_row;
  import frog_pkg::*;

  typedef struct packed {
    logic        l, r, u, d, hit, spawn, load, dir;
    logic [15:0] above, below, pat;
    logic [7:0]  period;
  } in_t;

  typedef struct {
    int          k;
    logic [15:0] frog;
    logic [15:0] lane;
    logic        hit;
  } exp_t;

  logic        clk;
  logic        reset;
  in_t         in_s   [3];
  logic [15:0] frog_w [3];
  logic [15:0] lane_w [3];
  logic [15:0] row_w  [3];
  logic        hit_w  [3];

  bit          wrap_m  [3] = '{1'b1, 1'b0, 1'b0};
  bit          river_m [3] = '{1'b0, 1'b0, 1'b1};
  logic [15:0] m_frog  [3];
  logic [15:0] m_lane  [3];
  int          m_cnt   [3];
  exp_t        sb[$];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    frog_lane_row #(
      .WIDTH     (16),
      .WRAP      (g == 0),
      .MODE      ((g == 2) ? LANE_RIVER : LANE_ROAD),
      .START_COL (7),
      .PER_W     (8)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .L          (in_s[g].l),
      .R          (in_s[g].r),
      .U          (in_s[g].u),
      .D          (in_s[g].d),
      .above_frog (in_s[g].above),
      .below_frog (in_s[g].below),
      .hit        (in_s[g].hit),
      .spawn      (in_s[g].spawn),
      .lane_load  (in_s[g].load),
      .lane_pat   (in_s[g].pat),
      .lane_dir   (in_s[g].dir),
      .period     (in_s[g].period),
      .frog       (frog_w[g]),
      .lane       (lane_w[g]),
      .row        (row_w[g]),
      .hit_o      (hit_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_frog[k] = '0;
      m_lane[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  // Behavioural next state of one row from the current model state and inputs.
  task automatic model_step(input int k);
    in_t         s;
    logic [15:0] f, ln, fn, lnn;
    int          c, nm;
    bit          step, off, coll;
    exp_t        e;
    s    = in_s[k];
    f    = m_frog[k];
    ln   = m_lane[k];
    c    = m_cnt[k];
    step = 1'b0;
    off  = 1'b0;
    lnn  = ln;
    if (s.load) begin
      lnn = s.pat;
      c   = 0;
    end else if (s.period != 0) begin
      if (c >= int'(s.period))          c = 0;
      else if (c == int'(s.period) - 1) begin c = 0; step = 1'b1; end
      else                              c = c + 1;
    end
    if (step) lnn = s.dir ? {ln[14:0], ln[15]} : {ln[0], ln[15:1]};

    nm = int'(s.l) + int'(s.r) + int'(s.u) + int'(s.d);
    fn = f;
    if (s.hit)        fn = 16'h0000;
    else if (s.spawn) fn = 16'h0080;
    else if (nm == 1) begin
      if (s.u)      fn = s.below;
      else if (s.d) fn = s.above;
      else if (s.l) fn = f[0]  ? (wrap_m[k] ? 16'h8000 : f) : (f >> 1);
      else          fn = f[15] ? (wrap_m[k] ? 16'h0001 : f) : (f << 1);
    end
    if (river_m[k] && step && !s.hit && !s.spawn && fn != 0) begin
      if (s.dir) begin
        if (fn[15]) begin
          if (wrap_m[k]) fn = 16'h0001; else begin fn = 0; off = 1'b1; end
        end else fn = fn << 1;
      end else begin
        if (fn[0]) begin
          if (wrap_m[k]) fn = 16'h8000; else begin fn = 0; off = 1'b1; end
        end else fn = fn >> 1;
      end
    end
    if (s.hit)           coll = 1'b0;
    else if (river_m[k]) coll = ((fn != 0) && ((fn & lnn) == 0)) || off;
    else                 coll = (fn & lnn) != 0;

    m_frog[k] = coll ? 16'h0000 : fn;
    m_lane[k] = lnn;
    m_cnt[k]  = c;
    e.k    = k;
    e.frog = m_frog[k];
    e.lane = lnn;
    e.hit  = coll;
    sb.push_back(e);
  endtask

  task automatic cycle();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq($sformatf("sb.d%0d.frog", e.k), 32'(frog_w[e.k]), 32'(e.frog));
      check_eq($sformatf("sb.d%0d.lane", e.k), 32'(lane_w[e.k]), 32'(e.lane));
      check_eq($sformatf("sb.d%0d.row", e.k),  32'(row_w[e.k]),  32'(e.frog | e.lane));
      check_eq($sformatf("sb.d%0d.hit", e.k),  32'(hit_w[e.k]),  32'(e.hit));
    end
    for (int k = 0; k < 3; k++) begin
      in_s[k].l     = 1'b0;
      in_s[k].r     = 1'b0;
      in_s[k].u     = 1'b0;
      in_s[k].d     = 1'b0;
      in_s[k].hit   = 1'b0;
      in_s[k].spawn = 1'b0;
      in_s[k].load  = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s.d%0d.frog", tag, k), 32'(frog_w[k]), 32'h0);
      check_eq($sformatf("%s.d%0d.lane", tag, k), 32'(lane_w[k]), 32'h0);
      check_eq($sformatf("%s.d%0d.hit", tag, k),  32'(hit_w[k]),  32'h0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) in_s[k] = '0;
    model_reset();
    reset = 1'b0;
    #2;
    check_all_zero("rst");
    reset = 1'b1;

    // Spawn on both road rows.
    in_s[0].spawn = 1'b1;
    in_s[1].spawn = 1'b1;
    cycle();
    check_eq("spawn.frog", 32'(frog_w[0]), 32'h0080);
    check_eq("spawn.hit",  32'(hit_w[0]),  32'h0);

    // Frog to bit 0, then L: wrap versus clamp.
    in_s[0].u = 1'b1; in_s[0].below = 16'h0001;
    in_s[1].u = 1'b1; in_s[1].below = 16'h0001;
    cycle();
    in_s[0].l = 1'b1;
    in_s[1].l = 1'b1;
    cycle();
    check_eq("wrap.L",  32'(frog_w[0]), 32'h8000);
    check_eq("clamp.L", 32'(frog_w[1]), 32'h0001);

    // Conflicting pulses hold; U copies below_frog; back-to-back R moves.
    in_s[0].l = 1'b1; in_s[0].r = 1'b1;
    cycle();
    check_eq("LR.hold", 32'(frog_w[0]), 32'h8000);
    in_s[0].u = 1'b1; in_s[0].below = 16'h0010;
    cycle();
    check_eq("U.below", 32'(frog_w[0]), 32'h0010);
    in_s[0].r = 1'b1;
    cycle();
    check_eq("R.1", 32'(frog_w[0]), 32'h0020);
    in_s[0].r = 1'b1;
    cycle();
    check_eq("R.2", 32'(frog_w[0]), 32'h0040);

    // Period shortened below the running count: restart without a step.
    in_s[0].load = 1'b1; in_s[0].pat = 16'h0001; in_s[0].dir = DIR_LOW; in_s[0].period = 8'd5;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    in_s[0].period = 8'd2;
    cycle();
    check_eq("per.nostep", 32'(lane_w[0]), 32'h0001);
    cycle();
    cycle();
    check_eq("per.step", 32'(lane_w[0]), 32'h8000);
    in_s[0].period = 8'd0;

    // Road collision: lane 0x0100 climbs to the frog at bit 10.
    in_s[1].u = 1'b1; in_s[1].below = 16'h0400;
    cycle();
    in_s[1].load = 1'b1; in_s[1].pat = 16'h0100; in_s[1].dir = DIR_HIGH; in_s[1].period = 8'd3;
    cycle();
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 2) check_eq("road.step1", 32'(lane_w[1]), 32'h0200);
      if (i == 4) check_eq("road.alive", 32'(frog_w[1]), 32'h0400);
      if (i == 5) begin
        check_eq("road.frog", 32'(frog_w[1]), 32'h0);
        check_eq("road.hit",  32'(hit_w[1]),  32'h1);
      end
      if (i == 6) check_eq("road.hitend", 32'(hit_w[1]), 32'h0);
    end
    in_s[1].period = 8'd0;

    // River with clamp: frog rides the log and is finally carried off.
    in_s[2].load = 1'b1; in_s[2].pat = 16'h6000; in_s[2].dir = DIR_HIGH; in_s[2].period = 8'd0;
    cycle();
    in_s[2].u = 1'b1; in_s[2].below = 16'h2000;
    cycle();
    check_eq("river.on", 32'(frog_w[2]), 32'h2000);
    in_s[2].period = 8'd2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 1) check_eq("river.c1", 32'(frog_w[2]), 32'h4000);
      if (i == 3) check_eq("river.c2", 32'(frog_w[2]), 32'h8000);
      if (i == 5) begin
        check_eq("river.off",  32'(frog_w[2]), 32'h0);
        check_eq("river.hit",  32'(hit_w[2]),  32'h1);
      end
    end
    in_s[2].period = 8'd0;

    // Global hit overrides a move and a colliding lane step.
    in_s[1].load = 1'b1; in_s[1].pat = 16'h0200; in_s[1].dir = DIR_LOW; in_s[1].spawn = 1'b1;
    cycle();
    check_eq("ghit.setup", 32'(frog_w[1]), 32'h0080);
    in_s[1].hit = 1'b1; in_s[1].r = 1'b1; in_s[1].period = 8'd1;
    cycle();
    check_eq("ghit.frog", 32'(frog_w[1]), 32'h0);
    check_eq("ghit.hit",  32'(hit_w[1]),  32'h0);
    check_eq("ghit.lane", 32'(lane_w[1]), 32'h0100);
    in_s[1].period = 8'd0;

    // Reset while the lane is stepping clears everything at once.
    in_s[0].period = 8'd1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    reset = 1'b1;
    in_s[0].spawn = 1'b1;
    cycle();
    check_eq("post.spawn", 32'(frog_w[0]), 32'h0080);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
